// File: rtl/arb_mux.sv
// N-channel round-robin arbitrated mux with a one-beat registered valid/ready output.
// Optional packet lock (in_last/out_last) is compiled in with `define ARBMUX_LAST_EN.
module arb_mux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
`ifdef ARBMUX_LAST_EN
    input  logic [N-1:0]   in_last,
    output logic           out_last,
`endif
    input  logic           out_ready
);

    logic [SW-1:0] ptr;
    logic          load;
    logic          found;
    logic [SW-1:0] gnt_idx;
    logic [N-1:0]  grant;
    logic [W-1:0]  gnt_data;

    logic          vld_p1;
    logic [W-1:0]  data_p1;
    logic [SW-1:0] sel_p1;

`ifdef ARBMUX_LAST_EN
    logic          locked;
    logic          gnt_last;
    logic          last_p1;
`endif

    // Channel after g, wrapping N-1 back to 0 for non-power-of-two N.
    function automatic logic [SW-1:0] ptr_after(input logic [SW-1:0] g);
        if (g == SW'(N - 1)) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    // Stage p0: arbitration and input select
    always_comb begin
        int c;
        found   = 1'b0;
        gnt_idx = '0;
        c       = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!found && in_valid[SW'(c)]) begin
                found   = 1'b1;
                gnt_idx = SW'(c);
            end
        end
`ifdef ARBMUX_LAST_EN
        // A packet in flight pins the grant to its channel, idle or not.
        if (locked) begin
            found   = in_valid[sel_p1];
            gnt_idx = sel_p1;
        end
`endif
    end

    always_comb begin
        grant    = '0;
        gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (found && (gnt_idx == SW'(k))) begin
                grant[k] = 1'b1;
                gnt_data = in_data[k*W +: W];
            end
        end
    end

`ifdef ARBMUX_LAST_EN
    assign gnt_last = in_last[gnt_idx];
`endif

    assign load     = !vld_p1 || out_ready;
    assign in_ready = (load && !rst) ? grant : '0;

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr     <= '0;
`ifdef ARBMUX_LAST_EN
            last_p1 <= 1'b0;
            locked  <= 1'b0;
`endif
        end else if (load) begin
            vld_p1 <= found;
            if (found) begin
                data_p1 <= gnt_data;
                sel_p1  <= gnt_idx;
`ifdef ARBMUX_LAST_EN
                last_p1 <= gnt_last;
                locked  <= !gnt_last;
                if (gnt_last) begin
                    ptr <= ptr_after(gnt_idx);
                end
`else
                ptr <= ptr_after(gnt_idx);
`endif
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
`ifdef ARBMUX_LAST_EN
    assign out_last  = last_p1;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux (N=4, W=8): vector table plus hand-written backpressure and lock sequences,
// with a scoreboard queue of expected output beats.
module tb_arb_mux;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;
`ifdef ARBMUX_LAST_EN
    logic [N-1:0]   in_last;
    logic           out_last;
`endif

    always #5 clk = ~clk;

    arb_mux #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef ARBMUX_LAST_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_ready (out_ready)
    );

    typedef struct {
        logic       r;
        logic [3:0] vld;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [SW-1:0] sel;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    beat_t      sb[$];
    logic [W-1:0] chan_data [N];
    vec_t       tbl [17];
    int         total = 0;
    int         bad   = 0;

    always_comb begin
        for (int k = 0; k < N; k++) in_data[k*W +: W] = chan_data[k];
    end

    function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [3:0] last,
                                input logic ordy, input logic [3:0] rdy, input logic ov);
        vec_t v;
        v.r = r; v.vld = vld; v.last = last; v.ordy = ordy; v.rdy = rdy; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle just after a rising edge, check at the falling edge.
    task automatic step(input vec_t v);
        beat_t b;
        beat_t e;
        int    g;
        rst       = v.r;
        in_valid  = v.vld;
        out_ready = v.ordy;
`ifdef ARBMUX_LAST_EN
        in_last   = v.last;
`endif
        @(negedge clk);
        chk("in_ready", in_ready, v.rdy);
        chk("out_valid", out_valid, v.ov);
        if (!v.r && v.ov && v.ordy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: output beat sel=%0d with no expected beat queued", out_sel);
            end else begin
                e = sb.pop_front();
                chk("out_sel", out_sel, e.sel);
                chk("out_data", out_data, e.data);
`ifdef ARBMUX_LAST_EN
                chk("out_last", out_last, e.last);
`endif
            end
        end
        if (v.r) begin
            sb.delete();
        end else if (|(v.vld & v.rdy)) begin
            g = 0;
            for (int k = 0; k < N; k++) if (v.rdy[k]) g = k;
            b.sel  = SW'(g);
            b.data = chan_data[g];
            b.last = v.last[g];
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) chan_data[k] = 8'hA0 + 8'(k);
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
`ifdef ARBMUX_LAST_EN
        in_last   = 4'h0;
`endif

        // reset held two cycles with every channel requesting
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_sel", out_sel, 0);
            chk("rst_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;

        //           rst vld      last  ordy rdy      ov
        tbl[0]  = mk(0, 4'b1111, 4'h0, 1, 4'b0001, 0);
        tbl[1]  = mk(0, 4'b1111, 4'h0, 1, 4'b0010, 1);
        tbl[2]  = mk(0, 4'b1111, 4'h0, 1, 4'b0100, 1);
        tbl[3]  = mk(0, 4'b1111, 4'h0, 1, 4'b1000, 1);
        tbl[4]  = mk(0, 4'b1111, 4'h0, 1, 4'b0001, 1);
        tbl[5]  = mk(0, 4'b1111, 4'h0, 1, 4'b0010, 1);
        tbl[6]  = mk(0, 4'b0000, 4'h0, 1, 4'b0000, 1);
        tbl[7]  = mk(0, 4'b0000, 4'h0, 1, 4'b0000, 0);
        tbl[8]  = mk(0, 4'b0100, 4'hF, 0, 4'b0100, 0);
        tbl[9]  = mk(0, 4'b0010, 4'hF, 0, 4'b0000, 1);
        tbl[10] = mk(1, 4'b0010, 4'hF, 0, 4'b0000, 1);
        tbl[11] = mk(0, 4'b1010, 4'hF, 1, 4'b0010, 0);
        tbl[12] = mk(0, 4'b1010, 4'hF, 1, 4'b1000, 1);
        tbl[13] = mk(0, 4'b1010, 4'hF, 1, 4'b0010, 1);
        tbl[14] = mk(0, 4'b1010, 4'hF, 1, 4'b1000, 1);
        tbl[15] = mk(0, 4'b0001, 4'hF, 1, 4'b0001, 1);
        tbl[16] = mk(0, 4'b0000, 4'hF, 1, 4'b0000, 1);
        for (int i = 0; i < 17; i++) step(tbl[i]);

        // backpressure: beat 8'h55 from channel 2 held three cycles, then drained with a same-edge load
        chan_data[2] = 8'h55;
        step(mk(0, 4'b0100, 4'hF, 1, 4'b0100, 0));
        for (int c = 0; c < 3; c++) begin
            step(mk(0, 4'b0001, 4'hF, 0, 4'b0000, 1));
            chk("hold_data", out_data, 8'h55);
            chk("hold_sel", out_sel, 2);
        end
        step(mk(0, 4'b0001, 4'hF, 1, 4'b0001, 1));
        step(mk(0, 4'b0000, 4'hF, 1, 4'b0000, 1));
        step(mk(0, 4'b0000, 4'hF, 1, 4'b0000, 0));

`ifdef ARBMUX_LAST_EN
        // packet lock: channel 2 sends three beats while 0 and 3 wait
        step(mk(0, 4'b1101, 4'b0000, 1, 4'b0100, 0));
        step(mk(0, 4'b1101, 4'b0000, 1, 4'b0100, 1));
        step(mk(0, 4'b1001, 4'b0000, 1, 4'b0000, 1));
        step(mk(0, 4'b1101, 4'b0100, 1, 4'b0100, 0));
        step(mk(0, 4'b1001, 4'b0000, 1, 4'b1000, 1));
        step(mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 1));
        step(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1));
        step(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0));
`endif

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
